// File: rtl/pb_bank_writer_pkg.sv
// Shared definitions for the 4-bank PB writer and its address generator.
package pb_bank_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2
  } wr_state_t;

  localparam int NUM_BANKS  = 4;
  localparam int BANK_SEL_W = 2;

  // PB lengths the reader's ROM set is built for
  localparam int PB_LEN_SHORT = 16;
  localparam int PB_LEN_MID   = 136;
  localparam int PB_LEN_LONG  = 520;

  // One-hot bank write enable from a bank index
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_SEL_W-1:0] sel);
    return NUM_BANKS'(1) << sel;
  endfunction

endpackage

// File: rtl/pb_bank_writer_addr_gen.sv
// Row / bank counters for the quarter-per-bank fill pattern.
// The beat presented with 'load' is always bank0 row0 of a fresh PB, using
// the live pb_len/pb_offset because the latched copies update on that edge.
module pb_quarter_addr_gen
  import pb_bank_writer_pkg::*;
#(
  parameter int A_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  adv,
  input  logic [A_WIDTH-1:0]    pb_len,
  input  logic [A_WIDTH-1:0]    pb_offset,
  output logic [BANK_SEL_W-1:0] wr_sel,
  output logic [A_WIDTH-1:0]    wr_addr,
  output logic                  last_beat
);

  logic [A_WIDTH-1:0]    len_l;
  logic [A_WIDTH-1:0]    off_l;
  logic [A_WIDTH-1:0]    row;
  logic [BANK_SEL_W-1:0] bank_sel;

  logic [A_WIDTH-1:0]    q_eff;
  logic [A_WIDTH-1:0]    off_eff;
  logic [A_WIDTH-1:0]    cur_row;
  logic [BANK_SEL_W-1:0] cur_sel;
  logic                  row_end;

  // Position of the beat currently presented, and where it lands
  always_comb begin
    q_eff     = load ? (pb_len >> 2) : (len_l >> 2);
    off_eff   = load ? pb_offset : off_l;
    cur_row   = load ? '0 : row;
    cur_sel   = load ? '0 : bank_sel;
    row_end   = (cur_row == (q_eff - A_WIDTH'(1)));
    wr_sel    = cur_sel;
    wr_addr   = cur_row + off_eff;   // wraps modulo 2^A_WIDTH by design
    last_beat = row_end & (cur_sel == BANK_SEL_W'(NUM_BANKS - 1));
  end

  // Latch geometry on sof, step row/bank on every written beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_l    <= '0;
      off_l    <= '0;
      row      <= '0;
      bank_sel <= '0;
    end else begin
      if (load) begin
        len_l <= pb_len;
        off_l <= pb_offset;
      end
      if (adv) begin
        row      <= row_end ? '0 : cur_row + A_WIDTH'(1);
        bank_sel <= row_end ? cur_sel + BANK_SEL_W'(1) : cur_sel;
      end else if (load) begin
        row      <= '0;
        bank_sel <= '0;
      end
    end
  end

endmodule

// File: rtl/pb_bank_writer.sv
// Serial PB stream to 4-bank writer; hands the filled banks to the reader.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a sof beat; ready only while the reader is idle
// FILL  | writing quarter k of the PB into bank k, one beat per write
// WAIT  | PB resident; rd_start pulsed, holding off until rd_busy drops
module pb_bank_writer
  import pb_bank_writer_pkg::*;
#(
  parameter int D_WIDTH = 2,
  parameter int A_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [A_WIDTH-1:0]   pb_len,
  input  logic [A_WIDTH-1:0]   pb_offset,
  input  logic                 sof,
  input  logic [D_WIDTH-1:0]   din,
  input  logic                 din_vld,
  output logic                 din_rdy,
  input  logic                 rd_busy,
  output logic [NUM_BANKS-1:0] bk_wen,
  output logic [A_WIDTH-1:0]   bk_waddr,
  output logic [D_WIDTH-1:0]   bk_wdata,
  output logic                 rd_start,
  output logic                 busy,
  output logic                 err
);

  wr_state_t state;
  wr_state_t state_nxt;

  logic                  accept;
  logic                  load;
  logic                  len_bad;
  logic                  do_write;
  logic                  err_set;
  logic                  fin;

  logic [BANK_SEL_W-1:0] wr_sel;
  logic [A_WIDTH-1:0]    wr_addr;
  logic                  last_beat;

  // A sof length must split into four non-empty equal quarters
  assign len_bad = (pb_len < A_WIDTH'(4)) | (pb_len[1:0] != 2'b00);

  pb_quarter_addr_gen #(
    .A_WIDTH (A_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .adv       (do_write),
    .pb_len    (pb_len),
    .pb_offset (pb_offset),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .last_beat (last_beat)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; WAIT is held for the rd_start cycle so the reader can raise rd_busy
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (do_write) state_nxt = FILL;
      end
      FILL: begin
        if (load)     state_nxt = len_bad ? IDLE : FILL;
        else if (fin) state_nxt = WAIT;
      end
      WAIT: begin
        if (!rd_start && !rd_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and per-beat decisions; a sof beat in FILL aborts and restarts
  always_comb begin
    din_rdy  = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    load     = 1'b0;
    do_write = 1'b0;
    err_set  = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE:    din_rdy = !rd_busy;
      FILL: begin
        din_rdy = 1'b1;
        busy    = 1'b1;
      end
      WAIT:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
    if (rst) din_rdy = 1'b0;
    accept = din_vld & din_rdy;
    if (accept) begin
      if (sof) begin
        load     = 1'b1;
        err_set  = len_bad | (state == FILL);
        do_write = !len_bad;
      end else if (state == FILL) begin
        do_write = 1'b1;
        fin      = last_beat;
      end
    end
  end

  // Registered bank write port and pulses; addr/data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bk_wen   <= '0;
      bk_waddr <= '0;
      bk_wdata <= '0;
      rd_start <= 1'b0;
      err      <= 1'b0;
    end else begin
      bk_wen <= do_write ? bank_onehot(wr_sel) : '0;
      if (do_write) begin
        bk_waddr <= wr_addr;
        bk_wdata <= din;
      end
      rd_start <= fin;
      err      <= err_set;
    end
  end

endmodule

// File: tb/tb_pb_bank_writer.sv
// Directed bench for pb_bank_writer: fill patterns, wrap, bad lengths,
// bursty input, abort-restart and reset mid-fill.
module tb_pb_bank_writer;

  localparam int DW = 2;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pb_len;
  logic [AW-1:0] pb_offset;
  logic          sof;
  logic [DW-1:0] din;
  logic          din_vld;
  logic          din_rdy;
  logic          rd_busy;
  logic [3:0]    bk_wen;
  logic [AW-1:0] bk_waddr;
  logic [DW-1:0] bk_wdata;
  logic          rd_start;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  pb_bank_writer #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_len    (pb_len),
    .pb_offset (pb_offset),
    .sof       (sof),
    .din       (din),
    .din_vld   (din_vld),
    .din_rdy   (din_rdy),
    .rd_busy   (rd_busy),
    .bk_wen    (bk_wen),
    .bk_waddr  (bk_waddr),
    .bk_wdata  (bk_wdata),
    .rd_start  (rd_start),
    .busy      (busy),
    .err       (err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Write/pulse log sampled 1 time unit after each rising edge
  int w_wen[$];
  int w_addr[$];
  int w_data[$];
  int n_start  = 0;
  int start_at = 0;
  int n_err    = 0;
  int err_at   = 0;

  always @(posedge clk) begin
    #1;
    if (bk_wen != 4'd0) begin
      w_wen.push_back(int'(bk_wen));
      w_addr.push_back(int'(bk_waddr));
      w_data.push_back(int'(bk_wdata));
    end
    if (rd_start) begin
      n_start++;
      start_at = w_wen.size();
    end
    if (err) begin
      n_err++;
      err_at = w_wen.size();
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send_beat(input logic s, input int d, input int gap);
    int t;
    t       = 0;
    din_vld = 1'b1;
    sof     = s;
    din     = DW'(d % 4);
    #1;
    while (!din_rdy && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!din_rdy) begin
      chk("rdy_timeout", int'(din_rdy), 1);
      din_vld = 1'b0;
      sof     = 1'b0;
      return;
    end
    @(negedge clk);
    din_vld = 1'b0;
    sof     = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // nbeats beats of pattern i%4, sof on the first; no gap after the last beat
  task automatic send_pb(input int len, input int off, input int nbeats, input int gap);
    @(negedge clk);
    pb_len    = AW'(len);
    pb_offset = AW'(off);
    for (int i = 0; i < nbeats; i++)
      send_beat(i == 0, i, (i == nbeats - 1) ? 0 : gap);
  endtask

  // Beat i of a PB goes to bank i/q, row i%q, address (off+row) mod 4096
  task automatic check_writes(input string tag, input int base, input int len,
                              input int off, input int cnt);
    int q;
    q = len / 4;
    for (int i = 0; i < cnt; i++) begin
      if (base + i < w_wen.size()) begin
        chk($sformatf("%s_wen%0d", tag, i),  w_wen[base+i],  1 << (i / q));
        chk($sformatf("%s_addr%0d", tag, i), w_addr[base+i], (off + i % q) % 4096);
        chk($sformatf("%s_data%0d", tag, i), w_data[base+i], i % 4);
      end else begin
        chk($sformatf("%s_missing%0d", tag, i), w_wen.size(), base + i + 1);
      end
    end
  endtask

  // Reader takes the banks for 3 cycles, then releases them
  task automatic release_reader(input string tag);
    rd_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("%s_wait_rdy%0d", tag, i), int'(din_rdy), 0);
      chk($sformatf("%s_wait_busy%0d", tag, i), int'(busy), 1);
    end
    rd_busy = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_rdy"}, int'(din_rdy), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"},   int'(din_rdy),  0);
    chk({tag, "_wen"},   int'(bk_wen),   0);
    chk({tag, "_waddr"}, int'(bk_waddr), 0);
    chk({tag, "_wdata"}, int'(bk_wdata), 0);
    chk({tag, "_start"}, int'(rd_start), 0);
    chk({tag, "_busy"},  int'(busy),     0);
    chk({tag, "_err"},   int'(err),      0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int s0;
    int e0;

    rst       = 1'b1;
    pb_len    = '0;
    pb_offset = '0;
    sof       = 1'b0;
    din       = '0;
    din_vld   = 1'b0;
    rd_busy   = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(negedge clk);

    // 1: len 16, offset 0, continuous
    base = w_wen.size(); s0 = n_start; e0 = n_err;
    send_pb(16, 0, 16, 0);
    chk("t1_nwr", w_wen.size() - base, 16);
    check_writes("t1", base, 16, 0, 16);
    chk("t1_nstart", n_start - s0, 1);
    chk("t1_start_at", start_at - base, 16);
    chk("t1_nerr", n_err - e0, 0);
    release_reader("t1");
    rd_busy = 1'b1;
    #1;
    chk("t1_idle_rdbusy_rdy", int'(din_rdy), 0);
    rd_busy = 1'b0;

    // 2: offset near the top of the address space
    base = w_wen.size(); s0 = n_start; e0 = n_err;
    send_pb(16, 4090, 16, 0);
    chk("t2a_nwr", w_wen.size() - base, 16);
    check_writes("t2a", base, 16, 4090, 16);
    chk("t2a_nstart", n_start - s0, 1);
    release_reader("t2a");
    base = w_wen.size(); s0 = n_start;
    send_pb(16, 4094, 16, 0);
    chk("t2b_nwr", w_wen.size() - base, 16);
    check_writes("t2b", base, 16, 4094, 16);
    chk("t2b_nstart", n_start - s0, 1);
    chk("t2_nerr", n_err - e0, 0);
    release_reader("t2b");

    // 3: illegal lengths
    base = w_wen.size(); e0 = n_err;
    send_pb(18, 0, 1, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("t3a_nerr", n_err - e0, 1);
    chk("t3a_nwr", w_wen.size() - base, 0);
    chk("t3a_busy", int'(busy), 0);
    chk("t3a_rdy", int'(din_rdy), 1);
    e0 = n_err;
    send_pb(2, 0, 1, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("t3b_nerr", n_err - e0, 1);
    chk("t3b_nwr", w_wen.size() - base, 0);
    chk("t3b_busy", int'(busy), 0);

    // 4: bursty input, one beat every third cycle, len 136
    base = w_wen.size(); s0 = n_start; e0 = n_err;
    send_pb(136, 0, 136, 2);
    chk("t4_nwr", w_wen.size() - base, 136);
    check_writes("t4", base, 136, 0, 136);
    chk("t4_nstart", n_start - s0, 1);
    chk("t4_start_at", start_at - base, 136);
    chk("t4_nerr", n_err - e0, 0);
    release_reader("t4");

    // 5: sof re-asserted after 7 beats restarts the PB
    base = w_wen.size(); s0 = n_start; e0 = n_err;
    send_pb(16, 0, 7, 0);
    send_beat(1'b1, 0, 0);
    for (int j = 1; j < 16; j++) send_beat(1'b0, j, 0);
    chk("t5_nwr", w_wen.size() - base, 23);
    check_writes("t5a", base, 16, 0, 7);
    check_writes("t5b", base + 7, 16, 0, 16);
    chk("t5_nerr", n_err - e0, 1);
    chk("t5_err_at", err_at - base, 8);
    chk("t5_nstart", n_start - s0, 1);
    chk("t5_start_at", start_at - base, 23);
    release_reader("t5");

    // 6: reset during FILL after 9 beats
    base = w_wen.size(); s0 = n_start;
    send_pb(16, 100, 9, 0);
    #1;
    chk("t6_pre_waddr", int'(bk_waddr), 100);
    chk("t6_pre_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("t6_rsthold");
    rst = 1'b0;
    base = w_wen.size();
    send_pb(16, 0, 16, 0);
    chk("t6_nwr", w_wen.size() - base, 16);
    check_writes("t6", base, 16, 0, 16);
    chk("t6_nstart", n_start - s0, 1);
    release_reader("t6");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pb_bank_writer.md
Name: pb_bank_writer

Overview:
- TX-side counterpart of the 4-bank parallel interleaver/deinterleaver reader.
- Accepts one PB as a serial D_WIDTH-per-beat stream with a valid/ready handshake.
- Splits the PB into four equal quarters and writes quarter k, in linear order, into bank k (ram0..ram3) at row offset pb_offset.
- When the PB is complete, issues a one-cycle start pulse to the parallel reader and holds off the next PB until the reader releases the banks.

Parameters:
D_WIDTH, 2, bits per data beat and per bank word
A_WIDTH, 12, address/length width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
pb_len  in  A_WIDTH  PB length in beats; sampled on accepted sof
pb_offset  in  A_WIDTH  bank row base; sampled on accepted sof
sof  in  1  start-of-PB; qualifies the first beat (valid only with din_vld)
din  in  D_WIDTH  data beat
din_vld  in  1  beat valid
din_rdy  out  1  writer can accept a beat
rd_busy  in  1  reader still consuming banks
bk_wen  out  4  one-hot bank write enable (bit k = ram k)
bk_waddr  out  A_WIDTH  bank row address
bk_wdata  out  D_WIDTH  bank write data
rd_start  out  1  one-cycle pulse: PB resident, reader may start
busy  out  1  FILL or WAIT state
err  out  1  one-cycle error pulse

Behaviour:
- Reset values: din_rdy=0, bk_wen=0, bk_waddr=0, bk_wdata=0, rd_start=0, busy=0, err=0. State is IDLE. Counters are 0. Latched len/offset are 0.
- Handshake: a beat transfers on clk edge with din_vld & din_rdy. din_rdy = (state==IDLE & !rd_busy) | (state==FILL).
- Geometry: q = len_l >> 2 (quarter). bank_sel (2b) and row (A_WIDTH) counters. Write address = row + off_l, modulo 2^A_WIDTH (wrap, no error).
- FSM states IDLE, FILL, WAIT.
- IDLE, on accepted beat with sof=1:
  - Latch len_l=pb_len, off_l=pb_offset.
  - If pb_len<4 or pb_len[1:0]!=0: pulse err, discard the beat, stay IDLE.
  - Otherwise write the beat as bank0 row0, set row=1, go to FILL. If q==1, that single beat completes quarter 0, so bank_sel advances and row is reset per the FILL rule.
- IDLE, accepted beat with sof=0: discarded, no err.
- FILL, each accepted beat with sof=0:
  - Write to bank bank_sel at row.
  - If row==q-1: row<=0 and bank_sel<=bank_sel+1. Otherwise row<=row+1.
  - When the last beat (bank_sel==3, row==q-1) is written, go to WAIT.
- FILL, accepted beat with sof=1: pulse err, abort the current PB, and restart from that beat exactly as the IDLE sof path does (relatch len/offset).
- WAIT: din_rdy=0. rd_start pulses for exactly one cycle on WAIT entry. Go to IDLE when rd_busy==0, no earlier than the cycle after rd_start. rd_busy is expected to rise within 1 cycle of rd_start.
- Write latency: bk_wen/bk_waddr/bk_wdata are registered, one cycle after the accepting edge. When no write is issued, bk_wen=0 and addr/data hold their last values.
- rd_start timing: asserts in the same cycle as the final bank write. The reader's ROM pipeline guarantees it reads after this write.
- busy = state!=IDLE.
- Simultaneous events: rd_busy high in IDLE blocks sof acceptance via din_rdy=0. err and a write may occur in the same cycle (abort-restart).
- Reset mid-FILL: all outputs go to reset values immediately. The partial PB is abandoned; bank contents are not cleared.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'd0, FILL=2'd1, WAIT=2'd2;
  - NUM_BANKS=4, BANK_SEL_W=2;
  - PB length constants shared with the reader's ROM set: 16, 136, 520.
- Optional sub-module pb_quarter_addr_gen holds the row/bank_sel counter, the q compare and the offset adder; the top keeps the FSM and handshake.

Test Plan:
1. pb_len=16, offset=0, din = beat index mod 4, continuous valid:
   - bk_wen one-hot 0001 for rows 0-3, then 0010, 0100, 1000;
   - bk_waddr 0..3 repeating;
   - rd_start pulses once, aligned with the 16th write;
   - din_rdy=0 until rd_busy drops.
2. pb_len=16, offset=4090: addresses 4090, 4091, 4092, 4093 in each bank; with q=4 there is no wrap. Repeat with offset=4094: addresses 4094, 4095, 0, 1 (modulo wrap), err=0.
3. pb_len=18 or pb_len=2 with sof: err=1 for one cycle, no bk_wen, state IDLE, busy=0.
4. Bursty din_vld (1 of every 3 cycles) for pb_len=136: exactly 136 writes, 34 per bank, rows 0..33; rd_start once.
5. sof re-asserted at beat 7 of a 16-beat PB: err pulse; that beat is written at bank0 row0; a full 16 more beats produce a normal rd_start.
6. rst asserted mid-FILL at beat 9 then released; new PB of 16 beats: outputs at reset values during rst; the new PB starts at bank0 row0; exactly one rd_start.
